// File: rtl/phase_a_arbiter.sv
// phase_a_arbiter
//   Round-robin scheduler sharing one phase_a reduction instance among NREQ
//   requesters. The winner's operand is latched onto pa_a, a single-cycle
//   pa_en pulse starts phase_a, and new_a is captured when en_out returns.
//   Optional watchdog: define PHASE_A_ARB_TIMEOUT_EN to abort a job after
//   TIMEOUT cycles in BUSY (err + done pulse, result untouched).
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : level request per requester, held until its done pulse
//   a_in        : flattened operands, requester i at [i*AW +: AW]
//   gnt         : one-hot grant, high from launch until completion
//   done        : one-cycle completion pulse on the served requester
//   result      : last captured pa_new_a
//   busy        : high whenever the FSM is not idle
//   err         : one-cycle watchdog abort pulse (0 without the macro)
//   pa_a, pa_en : operand and start pulse towards phase_a
//   pa_new_a, pa_en_out : result and completion strobe from phase_a
module phase_a_arbiter #(
  parameter int unsigned Size    = 3072,
  parameter int unsigned radix   = 78,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 31,
  localparam int unsigned AW     = Size + radix + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   a_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [Size-1:0]      result,
  output logic                 busy,
  output logic                 err,
  output logic [AW-1:0]        pa_a,
  output logic                 pa_en,
  input  logic [Size-1:0]      pa_new_a,
  input  logic                 pa_en_out
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [Size-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   pa_a_q, pa_a_d;
  logic            pa_en_q, pa_en_d;

`ifdef PHASE_A_ARB_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Round-robin search: first asserted request at or after ptr, with wrap.
  // The sum is one bit wider than the pointer so non-power-of-two NREQ wraps
  // correctly.
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     sum;
  logic [PW-1:0]   cand;
  logic [AW-1:0]   win_a;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    win_a     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == PW'(k)) begin
        win_a = a_in[k*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    pa_a_d   = pa_a_q;
    pa_en_d  = 1'b0;
`ifdef PHASE_A_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_LAUNCH;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          pa_a_d         = win_a;
          pa_en_d        = 1'b1;
          ptr_d          = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
        end
      end
      S_LAUNCH: begin
        state_d = S_BUSY;
`ifdef PHASE_A_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_BUSY: begin
        if (pa_en_out) begin
          state_d  = S_DONE;
          result_d = pa_new_a;
          done_d   = gnt_q;
          gnt_d    = '0;
        end
`ifdef PHASE_A_ARB_TIMEOUT_EN
        // wd counts completed BUSY cycles; abort on the TIMEOUT-th one.
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          gnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      pa_a_q   <= '0;
      pa_en_q  <= 1'b0;
`ifdef PHASE_A_ARB_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      pa_a_q   <= pa_a_d;
      pa_en_q  <= pa_en_d;
`ifdef PHASE_A_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign pa_a   = pa_a_q;
  assign pa_en  = pa_en_q;
`ifdef PHASE_A_ARB_TIMEOUT_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_phase_a_arbiter.sv
module tb_phase_a_arbiter;
  localparam int unsigned Size    = 3072;
  localparam int unsigned radix   = 78;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 31;
  localparam int unsigned AW      = Size + radix + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  a_in;
  logic [NREQ-1:0]     gnt, done;
  logic [Size-1:0]     result;
  logic                busy, err;
  logic [AW-1:0]       pa_a;
  logic                pa_en;
  logic [Size-1:0]     pa_new_a;
  logic                pa_en_out;

  logic                rsp_en_out = 1'b0;
  logic [Size-1:0]     rsp_new_a  = '0;
  logic                spur_en_out = 1'b0;
  logic [Size-1:0]     spur_new_a  = '0;
  assign pa_en_out = rsp_en_out | spur_en_out;
  assign pa_new_a  = spur_en_out ? spur_new_a : rsp_new_a;

  phase_a_arbiter #(
    .Size(Size), .radix(radix), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .err(err),
    .pa_a(pa_a), .pa_en(pa_en), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 64 bits) t=%0t", name, act[63:0], exp[63:0], $time);
    end
  endtask

  // phase_a stand-in: answers pa_en after lat cycles (lat==0 means never).
  int              lat = 3;
  int              rsp_cnt = 0;
  bit              rsp_fixed = 1'b0;
  logic [Size-1:0] resp_val = '0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rsp_cnt    = 0;
      rsp_en_out = 1'b0;
    end else begin
      rsp_en_out = 1'b0;
      if (pa_en === 1'b1 && lat > 0) begin
        rsp_cnt = lat;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_en_out = 1'b1;
          rsp_new_a  = rsp_fixed ? resp_val : (pa_a[Size-1:0] ^ resp_val);
        end
      end
    end
  end

  // Behavioural model: a job is described by its launch edge and completion
  // edge; outputs follow from those edge numbers.
  int              e_cnt = 0;
  bit              m_act;
  int              m_launch, m_done_at, m_err_at, m_ptr, m_win;
  logic [AW-1:0]   m_pa_a;
  logic [Size-1:0] m_result;
  logic [NREQ-1:0] m_oh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_launch = -100; m_done_at = -100; m_err_at = -100;
      m_ptr = 0; m_win = 0; m_pa_a = '0; m_result = '0;
    end else begin
      e_cnt++;
      if (m_act && (e_cnt - 1) > m_launch) begin
        if (pa_en_out) begin
          m_result = pa_new_a; m_done_at = e_cnt; m_act = 0;
        end
`ifdef PHASE_A_ARB_TIMEOUT_EN
        else if ((e_cnt - 1) - m_launch == int'(TIMEOUT)) begin
          m_done_at = e_cnt; m_err_at = e_cnt; m_act = 0;
        end
`endif
      end else if (!m_act && e_cnt >= m_done_at + 2 && req != '0) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (!m_act && req[(m_ptr + k) % NREQ]) begin
            m_win = (m_ptr + k) % NREQ;
            m_act = 1;
          end
        end
        m_launch = e_cnt;
        m_pa_a   = a_in[m_win*AW +: AW];
        m_ptr    = (m_win + 1) % NREQ;
      end
    end
  end

  int low_run = 0;
  bit seen_en = 0;
  int grant_log[$];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      seen_en = 0;
      low_run = 0;
    end else begin
      m_oh = '0;
      m_oh[m_win] = 1'b1;
      chk("busy",   AW'(busy),   AW'(m_act || e_cnt == m_done_at));
      chk("gnt",    AW'(gnt),    AW'(m_act ? m_oh : '0));
      chk("done",   AW'(done),   AW'((e_cnt == m_done_at) ? m_oh : '0));
      chk("pa_en",  AW'(pa_en),  AW'(m_act && e_cnt == m_launch));
      chk("err",    AW'(err),    AW'(e_cnt == m_err_at));
      chk("pa_a",   pa_a,        m_pa_a);
      chk("result", AW'(result), AW'(m_result));
      if (pa_en === 1'b1) begin
        if (seen_en) chk("pa_en_gap_ge2", AW'(low_run >= 2), AW'(1));
        for (int k = 0; k < int'(NREQ); k++) if (gnt[k]) grant_log.push_back(k);
        seen_en = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic wait_pa_en(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (pa_en === 1'b1) break;
    end
    chk("wait_pa_en", AW'(pa_en), AW'(1));
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done !== '0) break;
    end
    chk("wait_done", AW'(|done), AW'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    AW'(gnt),    '0);
    chk({tag, "_done"},   AW'(done),   '0);
    chk({tag, "_result"}, AW'(result), '0);
    chk({tag, "_busy"},   AW'(busy),   '0);
    chk({tag, "_err"},    AW'(err),    '0);
    chk({tag, "_pa_a"},   pa_a,        '0);
    chk({tag, "_pa_en"},  AW'(pa_en),  '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  logic [AW-1:0]   s, slice0;
  logic [Size-1:0] r_keep;
  int              n;

  initial begin
    rst_n = 1'b0; req = '0; a_in = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      for (int b = 0; b < int'(AW); b++) s[b] = 1'($urandom_range(0, 1));
      if (i == 0) begin
        s[7:0] = 8'hA5;
        s[AW-1 -: 8] = 8'h5A;
        slice0 = s;
      end
      a_in[i*AW +: AW] = s;
    end
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job from requester 0 with a fixed returned value.
    rsp_fixed = 1'b1; resp_val = Size'(32'h1234); lat = 3;
    req = 4'b0001;
    wait_pa_en(10, n);
    chk("t1_launch_latency", AW'(n), AW'(1));
    chk("t1_pa_a", pa_a, slice0);
    chk("t1_gnt", AW'(gnt), AW'(4'b0001));
    wait_done(20, n);
    chk("t1_done_latency", AW'(n), AW'(4));
    chk("t1_done", AW'(done), AW'(4'b0001));
    chk("t1_result", AW'(result), AW'(32'h1234));
    req = '0;
    @(negedge clk);
    chk("t1_done_one_cycle", AW'(done), '0);

    // All requesting: pointer sits at 1 after the first job.
    rsp_fixed = 1'b0; resp_val = Size'(32'hC0FFEE); lat = 2;
    grant_log.delete();
    req = 4'b1111;
    wait_pa_en(10, n);
    for (int j = 1; j < 5; j++) begin
      wait_pa_en(20, n);
      chk("t3_b2b_spacing", AW'(n), AW'(5));
    end
    req = '0;
    wait_done(20, n);
    chk("t3_grant_count", AW'(grant_log.size()), AW'(5));
    if (grant_log.size() == 5) begin
      chk("t3_order0", AW'(grant_log[0]), AW'(1));
      chk("t3_order1", AW'(grant_log[1]), AW'(2));
      chk("t3_order2", AW'(grant_log[2]), AW'(3));
      chk("t3_order3", AW'(grant_log[3]), AW'(0));
      chk("t3_order4", AW'(grant_log[4]), AW'(1));
    end
    @(negedge clk);

    // Requester 2 drops while busy; next pending (3) follows.
    lat = 4;
    req = 4'b1101;
    wait_pa_en(10, n);
    chk("t4_gnt2", AW'(gnt), AW'(4'b0100));
    @(negedge clk);
    req = 4'b1001;
    wait_done(20, n);
    chk("t4_done2", AW'(done), AW'(4'b0100));
    wait_pa_en(10, n);
    chk("t4_gnt3", AW'(gnt), AW'(4'b1000));
    req = '0;
    wait_done(20, n);
    chk("t4_done3", AW'(done), AW'(4'b1000));
    repeat (4) @(negedge clk);
    chk("t4_dropped_req_discarded", AW'(busy), '0);

    // Spurious en_out while idle.
    r_keep = result;
    spur_new_a = Size'(32'hDEAD);
    spur_en_out = 1'b1;
    @(negedge clk);
    spur_en_out = 1'b0;
    chk("t5_no_done", AW'(done), '0);
    chk("t5_result_kept", AW'(result), AW'(r_keep));
    @(negedge clk);
    chk("t5_no_done2", AW'(done), '0);
    chk("t5_idle", AW'(busy), '0);

    // Reset in the middle of a job.
    lat = 50;
    req = 4'b0001;
    wait_pa_en(10, n);
    repeat (5) @(negedge clk);
    req = '0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_midreset");
    @(negedge clk);
    req = 4'b0100; lat = 2;
    @(negedge clk);
    rst_n = 1'b1;
    wait_pa_en(10, n);
    chk("t6_latency", AW'(n), AW'(1));
    chk("t6_gnt2", AW'(gnt), AW'(4'b0100));
    wait_done(20, n);
    req = '0;
    @(negedge clk);

`ifdef PHASE_A_ARB_TIMEOUT_EN
    // No answer from phase_a: watchdog abort.
    lat = 0;
    r_keep = result;
    req = 4'b0010;
    wait_pa_en(10, n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (err === 1'b1) break;
    end
    chk("t7_err_seen", AW'(err), AW'(1));
    chk("t7_err_latency", AW'(n), AW'(32));
    chk("t7_done", AW'(done), AW'(4'b0010));
    chk("t7_result_kept", AW'(result), AW'(r_keep));
    req = '0;
    @(negedge clk);
    chk("t7_err_one_cycle", AW'(err), '0);
`else
    // No answer from phase_a: the job waits indefinitely.
    lat = 0;
    req = 4'b0010;
    wait_pa_en(10, n);
    req = '0;
    repeat (40) @(negedge clk);
    chk("t7_still_busy", AW'(busy), AW'(1));
    chk("t7_still_gnt", AW'(gnt), AW'(4'b0010));
    chk("t7_no_err", AW'(err), '0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
